// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: debounced single-step / free-running clock generator for a multicycle processor
module clock_step_ctrl #(
    parameter int DB_CYCLES  = 500000,
    parameter int PULSE_HIGH = 2500000,
    parameter int AUTO_BASE  = 12500000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        KeyN,
    input  logic        Auto,
    input  logic [1:0]  RateSel,
    output logic        ProcClock,
    output logic        StepPulse,
    output logic [15:0] StepCount,
    output logic        Busy
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW_GAP} state_t;
    localparam logic [31:0] DB_LAST = DB_CYCLES - 1;
    localparam logic [31:0] PULSE_U = PULSE_HIGH;
    localparam logic [31:0] AUTO_U  = AUTO_BASE;
    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, db_q, db_d, press_q, press_d;
    logic        proc_q, proc_d, step_q, step_d, enter_high;
    logic [31:0] db_cnt_q, db_cnt_d, ph_cnt_q, ph_cnt_d, len_q, len_d;
    logic [31:0] auto_len, new_len;
    logic [15:0] count_q, count_d;
    assign auto_len = AUTO_U >> RateSel;
    assign new_len  = Auto ? ((auto_len == 32'd0) ? 32'd1 : auto_len) : PULSE_U;
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        // any sample that agrees with the debounced level restarts the window
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) db_d = sync2_q;
            else db_cnt_d = db_cnt_q + 32'd1;
        end
        press_d    = db_q & ~db_d;
        state_d    = state_q;
        ph_cnt_d   = ph_cnt_q + 32'd1;
        len_d      = len_q;
        enter_high = 1'b0;
        case (state_q)
            IDLE: begin
                ph_cnt_d   = '0;
                enter_high = Auto | press_q;
            end
            HIGH: begin
                if (ph_cnt_q == len_q - 32'd1) begin
                    state_d  = LOW_GAP;
                    ph_cnt_d = '0;
                end
            end
            LOW_GAP: begin
                if (ph_cnt_q == len_q - 32'd1) begin
                    state_d    = IDLE;
                    ph_cnt_d   = '0;
                    enter_high = Auto;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_high) begin
            state_d  = HIGH;
            ph_cnt_d = '0;
            len_d    = new_len;
        end
        proc_d  = (state_d == HIGH);
        step_d  = enter_high;
        count_d = count_q + {15'b0, enter_high};
    end
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            db_q     <= 1'b1;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
            state_q  <= IDLE;
            ph_cnt_q <= '0;
            len_q    <= '0;
            proc_q   <= 1'b0;
            step_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            sync1_q  <= KeyN;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
            state_q  <= state_d;
            ph_cnt_q <= ph_cnt_d;
            len_q    <= len_d;
            proc_q   <= proc_d;
            step_q   <= step_d;
            count_q  <= count_d;
        end
    end
    assign ProcClock = proc_q;
    assign StepPulse = step_q;
    assign StepCount = count_q;
    assign Busy      = (state_q != IDLE);
endmodule
